// File: rtl/des_req_arbiter.sv
// des_req_arbiter: round-robin front end sharing one des_core between two
// host requesters. An accepted request is latched, the core gets a single
// encipher/decipher strobe, the ready handshake is tracked and the 64-bit
// result is returned on the granted port. A watchdog aborts a stalled core.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/mode/data/key    request N (mode 0=encrypt, 1=decrypt)
//   reqN_ready                  accept pulse, inputs sampled in that cycle
//   rspN_valid/err/data         result pulse N, err=1 on watchdog abort
//   des_encipher_en/decipher_en core strobes
//   des_data, des_key_in        latched core operands
//   desc_result, desc_ready     core result and idle/result-valid flag
//   busy                        arbiter not idle
//
// Optional feature: define DES_ARB_CBC_EN to add reqN_iv_load/reqN_iv and a
// per-port CBC chain register. Without it the block is pure ECB.
module des_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TCNT_W         = 8,
    localparam int unsigned BLK_W         = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req0_mode,
    input  logic [BLK_W-1:0] req0_data,
    input  logic [BLK_W-1:0] req0_key,
`ifdef DES_ARB_CBC_EN
    input  logic             req0_iv_load,
    input  logic [BLK_W-1:0] req0_iv,
`endif
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_mode,
    input  logic [BLK_W-1:0] req1_data,
    input  logic [BLK_W-1:0] req1_key,
`ifdef DES_ARB_CBC_EN
    input  logic             req1_iv_load,
    input  logic [BLK_W-1:0] req1_iv,
`endif
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp0_err,
    output logic [BLK_W-1:0] rsp0_data,
    output logic             rsp1_valid,
    output logic             rsp1_err,
    output logic [BLK_W-1:0] rsp1_data,
    output logic             des_encipher_en,
    output logic             des_decipher_en,
    output logic [BLK_W-1:0] des_data,
    output logic [BLK_W-1:0] des_key_in,
    input  logic [BLK_W-1:0] desc_result,
    input  logic             desc_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RESP
    } state_t;

    // Watchdog value in the last cycle before the abort fires.
    localparam logic [TCNT_W-1:0] WD_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    run_q;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic                    mode_q, mode_d;
    logic [BLK_W-1:0]        data_q, data_d;
    logic [BLK_W-1:0]        key_q, key_d;
    logic                    enc_q, enc_d;
    logic                    dec_q, dec_d;
    logic                    busy_q, busy_d;
    logic [TCNT_W-1:0]       wd_q, wd_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [1:0]              rsp_err_q, rsp_err_d;
    logic [1:0][BLK_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef DES_ARB_CBC_EN
    logic [1:0][BLK_W-1:0]   chain_q, chain_d;
    logic                    sel_iv_load_c;
    logic [BLK_W-1:0]        sel_iv_c;
    logic [BLK_W-1:0]        eff_chain_c;
`endif

    logic                    accept_c;
    logic                    pick_c;
    logic                    sel_mode_c;
    logic [BLK_W-1:0]        sel_data_c;
    logic [BLK_W-1:0]        sel_key_c;
    logic                    abort_c;

    // Request selection: sole valid port wins, a tie goes to the port that
    // was not served last. run_q keeps ready low while reset is asserted.
    always_comb begin
        pick_c     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept_c   = run_q && (state_q == S_IDLE) && desc_ready
                     && (req0_valid || req1_valid);
        sel_mode_c = pick_c ? req1_mode : req0_mode;
        sel_data_c = pick_c ? req1_data : req0_data;
        sel_key_c  = pick_c ? req1_key  : req0_key;
`ifdef DES_ARB_CBC_EN
        sel_iv_load_c = pick_c ? req1_iv_load : req0_iv_load;
        sel_iv_c      = pick_c ? req1_iv      : req0_iv;
        eff_chain_c   = sel_iv_load_c ? sel_iv_c : chain_q[pick_c];
`endif
    end

    assign req0_ready = accept_c && !pick_c;
    assign req1_ready = accept_c &&  pick_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mode_d       = mode_q;
        data_d       = data_q;
        key_d        = key_q;
        enc_d        = 1'b0;
        dec_d        = 1'b0;
        wd_d         = wd_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 2'b00;
        rsp_data_d   = rsp_data_q;
        abort_c      = 1'b0;
`ifdef DES_ARB_CBC_EN
        chain_d      = chain_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    grant_d = pick_c;
                    mode_d  = sel_mode_c;
                    key_d   = sel_key_c;
`ifdef DES_ARB_CBC_EN
                    chain_d[pick_c] = eff_chain_c;
                    data_d = sel_mode_c ? sel_data_c : (sel_data_c ^ eff_chain_c);
`else
                    data_d = sel_data_c;
`endif
                    enc_d   = ~sel_mode_c;
                    dec_d   = sel_mode_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                wd_d = wd_q + TCNT_W'(1);
                // Core progress wins over a watchdog expiring in the same cycle.
                if (!desc_ready) begin
                    state_d = S_WAIT_HIGH;
                end else if (wd_q == WD_LAST) begin
                    abort_c = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                wd_d = wd_q + TCNT_W'(1);
                if (desc_ready) begin
                    rsp_valid_d[grant_q] = 1'b1;
`ifdef DES_ARB_CBC_EN
                    if (mode_q) begin
                        rsp_data_d[grant_q] = desc_result ^ chain_q[grant_q];
                        chain_d[grant_q]    = data_q;
                    end else begin
                        rsp_data_d[grant_q] = desc_result;
                        chain_d[grant_q]    = desc_result;
                    end
`else
                    rsp_data_d[grant_q] = desc_result;
`endif
                    state_d = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    abort_c = 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog abort: error response, zero data, chain untouched.
        if (abort_c) begin
            rsp_valid_d[grant_q] = 1'b1;
            rsp_err_d[grant_q]   = 1'b1;
            rsp_data_d[grant_q]  = '0;
            last_grant_d         = grant_q;
            state_d              = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            run_q        <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mode_q       <= 1'b0;
            data_q       <= '0;
            key_q        <= '0;
            enc_q        <= 1'b0;
            dec_q        <= 1'b0;
            busy_q       <= 1'b0;
            wd_q         <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp_data_q   <= '0;
`ifdef DES_ARB_CBC_EN
            chain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mode_q       <= mode_d;
            data_q       <= data_d;
            key_q        <= key_d;
            enc_q        <= enc_d;
            dec_q        <= dec_d;
            busy_q       <= busy_d;
            wd_q         <= wd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
`ifdef DES_ARB_CBC_EN
            chain_q      <= chain_d;
`endif
        end
    end

    assign des_encipher_en = enc_q;
    assign des_decipher_en = dec_q;
    assign des_data        = data_q;
    assign des_key_in      = key_q;
    assign busy            = busy_q;
    assign rsp0_valid      = rsp_valid_q[0];
    assign rsp1_valid      = rsp_valid_q[1];
    assign rsp0_err        = rsp_err_q[0];
    assign rsp1_err        = rsp_err_q[1];
    assign rsp0_data       = rsp_data_q[0];
    assign rsp1_data       = rsp_data_q[1];

endmodule

// File: tb/tb_des_req_arbiter.sv
// tb_des_req_arbiter: scoreboard bench for des_req_arbiter with a behavioural
// core model (known DES vector plus an invertible stand-in cipher).
`timescale 1ns/1ps
module tb_des_req_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned TW = 5;
    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] P2 = 64'hDEADBEEF00C0FFEE;
    localparam logic [63:0] MASK = 64'hA5A55A5AC3C33C3C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_mode = 1'b0;
    logic [63:0] req0_data = '0, req0_key = '0;
    logic        req1_valid = 1'b0, req1_mode = 1'b0;
    logic [63:0] req1_data = '0, req1_key = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [63:0] rsp0_data, rsp1_data;
    logic        des_encipher_en, des_decipher_en;
    logic [63:0] des_data, des_key_in;
    logic [63:0] desc_result = '0;
    logic        desc_ready = 1'b1;
    logic        busy;
`ifdef DES_ARB_CBC_EN
    logic        req0_iv_load = 1'b0, req1_iv_load = 1'b0;
    logic [63:0] req0_iv = '0, req1_iv = '0;
    logic        g_ivl = 1'b1;
    logic [63:0] g_iv = '0;
`endif

    always #5 clk = ~clk;

    des_req_arbiter #(.TIMEOUT_CYCLES(TO), .TCNT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_mode(req0_mode),
        .req0_data(req0_data), .req0_key(req0_key),
`ifdef DES_ARB_CBC_EN
        .req0_iv_load(req0_iv_load), .req0_iv(req0_iv),
        .req1_iv_load(req1_iv_load), .req1_iv(req1_iv),
`endif
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_mode(req1_mode),
        .req1_data(req1_data), .req1_key(req1_key),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_data(rsp1_data),
        .des_encipher_en(des_encipher_en), .des_decipher_en(des_decipher_en),
        .des_data(des_data), .des_key_in(des_key_in),
        .desc_result(desc_result), .desc_ready(desc_ready),
        .busy(busy)
    );

    // Reference cipher: the published DES vector, else rotl13((d^k))^MASK.
    function automatic logic [63:0] model_enc(input logic [63:0] k, input logic [63:0] d);
        logic [63:0] t;
        if (k == K1 && d == P1) return C1;
        t = d ^ k;
        return {t[50:0], t[63:51]} ^ MASK;
    endfunction

    function automatic logic [63:0] model_dec(input logic [63:0] k, input logic [63:0] d);
        logic [63:0] t;
        if (k == K1 && d == C1) return P1;
        t = d ^ MASK;
        t = {t[12:0], t[63:13]};
        return t ^ k;
    endfunction

    // Core model: ready drops the cycle after a strobe, result 3 cycles later.
    bit          stall = 1'b0;
    int          core_cnt = 0;
    logic        core_dec = 1'b0;
    logic [63:0] core_d = '0, core_k = '0;
    always @(posedge clk) begin
        if (!stall && (des_encipher_en || des_decipher_en)) begin
            desc_ready <= 1'b0;
            core_cnt   <= 3;
            core_dec   <= des_decipher_en;
            core_d     <= des_data;
            core_k     <= des_key_in;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                desc_ready  <= 1'b1;
                desc_result <= core_dec ? model_dec(core_k, core_d) : model_enc(core_k, core_d);
            end
        end
    end

    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last0 = '0, last1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic e, input logic [63:0] d);
        exp_q.push_back('{port: p, err: e, data: d});
    endtask

    // Response scoreboard, strobe timing and handshake monitor.
    logic [1:0] dr_h = 2'b11;
    logic [1:0] exp_strobe = 2'b00;
    always @(negedge clk) begin : mon
        exp_t        e;
        logic        ap, ae;
        logic [63:0] ad, other, other_exp;
        if (rsp0_valid || rsp1_valid) begin
            checks++;
            if (rsp0_valid && rsp1_valid) begin
                errors++;
                $display("FAIL rsp_onehot: both rsp valids high");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: port %0d data %h, none expected",
                         rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data);
            end else begin
                e  = exp_q.pop_front();
                ap = rsp1_valid;
                ae = rsp1_valid ? rsp1_err : rsp0_err;
                ad = rsp1_valid ? rsp1_data : rsp0_data;
                if (ap !== e.port || ae !== e.err || ad !== e.data) begin
                    errors++;
                    $display("FAIL rsp: got port %0d err %0d data %h expected port %0d err %0d data %h",
                             ap, ae, ad, e.port, e.err, e.data);
                end
                if (e.port) last1 = e.data; else last0 = e.data;
                other     = e.port ? rsp0_data : rsp1_data;
                other_exp = e.port ? last0 : last1;
                chk("rsp_other_hold", other, other_exp);
                if (!e.err) chk("rsp_latency", 64'(dr_h), 64'(2'b01));
            end
        end
        if (req0_ready && req1_ready) chk("ready_onehot", 64'({req0_ready, req1_ready}), 64'(2'b10));
        if (des_encipher_en || des_decipher_en || exp_strobe != 2'b00)
            chk("strobe", 64'({des_encipher_en, des_decipher_en}), 64'(exp_strobe));
        exp_strobe = req0_ready ? (req0_mode ? 2'b01 : 2'b10) :
                     req1_ready ? (req1_mode ? 2'b01 : 2'b10) : 2'b00;
        dr_h = {dr_h[0], desc_ready};
    end

    // Present a request at a negedge and hold it until accepted.
    task automatic issue(input logic port, input logic mode, input logic [63:0] key,
                         input logic [63:0] data);
        int  n = 0;
        bit  got = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_mode = mode; req1_key = key; req1_data = data;
`ifdef DES_ARB_CBC_EN
            req1_iv_load = g_ivl; req1_iv = g_iv;
`endif
        end else begin
            req0_valid = 1'b1; req0_mode = mode; req0_key = key; req0_data = data;
`ifdef DES_ARB_CBC_EN
            req0_iv_load = g_ivl; req0_iv = g_iv;
`endif
        end
        while (!got && n < 300) begin
            #1;
            got = port ? req1_ready : req0_ready;
            @(negedge clk);
            n++;
        end
        chk(port ? "accept1" : "accept0", 64'(got), 64'(1));
        chk(port ? "ready1_pulse" : "ready0_pulse", 64'(port ? req1_ready : req0_ready), 64'(0));
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 64'({busy, exp_q.size() != 0}), 64'(0));
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                                 rsp1_err, des_encipher_en, des_decipher_en, busy}), 64'(0));
        chk({tag, "_rsp0_data"}, rsp0_data, 64'(0));
        chk({tag, "_rsp1_data"}, rsp1_data, 64'(0));
        chk({tag, "_des_data"}, des_data, 64'(0));
        chk({tag, "_des_key"}, des_key_in, 64'(0));
    endtask

    initial begin : stim
        logic [63:0] c_k2;
        int          n;
`ifdef DES_ARB_CBC_EN
        logic [63:0] c2;
`endif
        c_k2 = model_enc(K2, P2);
        repeat (2) @(negedge clk);
        chk_zero("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single encrypt on port 0, then single decrypt on port 1.
        push(1'b0, 1'b0, C1);
        issue(1'b0, 1'b0, K1, P1);
        wait_idle();
        push(1'b1, 1'b0, P1);
        issue(1'b1, 1'b1, K1, C1);
        wait_idle();

        // Both ports continuously valid: grants alternate 0,1,0,1.
        push(1'b0, 1'b0, C1);
        push(1'b1, 1'b0, P1);
        push(1'b0, 1'b0, c_k2);
        push(1'b1, 1'b0, P2);
        fork
            begin issue(1'b0, 1'b0, K1, P1); issue(1'b0, 1'b0, K2, P2); end
            begin issue(1'b1, 1'b1, K1, C1); issue(1'b1, 1'b1, K2, c_k2); end
        join
        wait_idle();

        // Stalled core: abort 16 cycles after WAIT_LOW entry (strobe + 17).
        stall = 1'b1;
        push(1'b0, 1'b1, 64'(0));
        issue(1'b0, 1'b0, K2, P2);
        n = 0;
        while (!rsp0_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(17));
        wait_idle();
        stall = 1'b0;
        push(1'b0, 1'b0, c_k2);
        issue(1'b0, 1'b0, K2, P2);
        wait_idle();

        // Reset during WAIT_HIGH: outputs clear at once, no response.
        push(1'b0, 1'b0, C1);
        issue(1'b0, 1'b0, K1, P1);
        n = 0;
        while (desc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        void'(exp_q.pop_back());
        last0 = '0;
        last1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 1'b0, C1);
        issue(1'b0, 1'b0, K1, P1);
        wait_idle();

`ifdef DES_ARB_CBC_EN
        // CBC chaining on port 0 with a zero IV.
        c2 = model_enc(K1, P1 ^ C1);
        g_ivl = 1'b1; g_iv = '0;
        push(1'b0, 1'b0, C1);
        issue(1'b0, 1'b0, K1, P1);
        wait_idle();
        g_ivl = 1'b0;
        push(1'b0, 1'b0, c2);
        issue(1'b0, 1'b0, K1, P1);
        wait_idle();
        g_ivl = 1'b1;
        push(1'b0, 1'b0, P1);
        issue(1'b0, 1'b1, K1, C1);
        wait_idle();
        g_ivl = 1'b0;
        push(1'b0, 1'b0, P1);
        issue(1'b0, 1'b1, K1, c2);
        wait_idle();
        g_ivl = 1'b1;
`endif

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/des_req_arbiter.md
Name: des_req_arbiter

Overview:
Shares one des_core instance between two requesters (host port 0, host port 1) using round-robin arbitration. Per accepted request, latches the data, key and mode, issues a single-cycle encipher/decipher strobe, tracks the core's ready handshake, and returns the 64-bit result to the granted requester. Sits between the board/host control logic and des_core, replacing direct key-press strobing of the core. Includes a watchdog that recovers from a stalled core.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT_LOW+WAIT_HIGH before aborting with error (>=4)
TCNT_W, 8, watchdog counter width; must satisfy 2**TCNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; single clock domain, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request pending; held until accepted
req0_mode / req1_mode  in  1  0=encrypt, 1=decrypt
req0_data / req1_data  in  64  input block
req0_key / req1_key  in  64  key incl. parity bits
req0_ready / req1_ready  out  1  one-cycle accept pulse; inputs sampled this cycle
rsp0_valid / rsp1_valid  out  1  one-cycle result pulse
rsp0_err / rsp1_err  out  1  qualifies rspN_valid; 1=watchdog abort
rsp0_data / rsp1_data  out  64  result; held until next rsp to same port
des_encipher_en  out  1  core encrypt strobe
des_decipher_en  out  1  core decrypt strobe
des_data  out  64  core data input, from internal latch
des_key_in  out  64  core key input, from internal latch
desc_result  in  64  core result
desc_ready  in  1  core idle/result valid
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, last_grant=1 (port 0 wins first tie), watchdog=0, latches=0.
- IDLE: if desc_ready=1 and any reqN_valid: grant = sole valid port, or on tie the port != last_grant. Latch data/key/mode, pulse reqN_ready, record grant -> START. If desc_ready=0, accept nothing.
- START: assert des_encipher_en (mode=0) or des_decipher_en (mode=1) for exactly one cycle; never both -> WAIT_LOW.
- WAIT_LOW: wait for desc_ready=0 -> WAIT_HIGH.
- WAIT_HIGH: on desc_ready=1 capture desc_result -> RESP.
- RESP: pulse rspN_valid for the granted port, rspN_err=0; last_grant<=grant -> IDLE.
- des_data/des_key_in stay stable from START until leaving WAIT_HIGH.
- Watchdog: cleared on entry to WAIT_LOW, increments each cycle in WAIT_LOW/WAIT_HIGH. On reaching TIMEOUT_CYCLES: pulse rspN_valid with rspN_err=1, rspN_data=0, update last_grant -> IDLE.
- Latency: accept at cycle T, strobe at T+1, rsp one cycle after the capture cycle.
- Non-granted requester: its valid is ignored until IDLE; no ready pulse, no state change.
- rspN_data of the other port is unchanged.
- Async reset mid-operation: immediate return to reset state; no rsp is issued for the aborted request.
- Requester deasserting valid before accept is legal; nothing is latched.

Optional Feature:
DES_ARB_CBC_EN: adds ports reqN_iv_load (1) and reqN_iv (64), plus a 64-bit chain register per port (reset 0).
- On accept with iv_load=1: chain <= iv before use.
- Encrypt: des_data = data ^ chain; on success chain <= result.
- Decrypt: des_data = data; rsp = result ^ chain; on success chain <= original ciphertext.
- Watchdog abort leaves the chain unchanged.
Without the macro: pure ECB; the extra ports and chain registers do not exist.

Test Plan:
- req0 encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF -> req0_ready 1 cycle; des_encipher_en high exactly 1 cycle; rsp0_valid with rsp0_data 85E813540F0AB405, rsp0_err 0; rsp1_valid stays 0.
- req1 decrypt, same key, data 85E813540F0AB405 -> rsp1_data 0123456789ABCDEF; des_decipher_en pulsed, des_encipher_en never high.
- Both valid continuously after reset, 4 requests -> grants in order 0,1,0,1; each rsp returns on the matching port.
- TIMEOUT_CYCLES=16; core model holds desc_ready=1 after the strobe -> rsp0_valid with rsp0_err=1 and rsp0_data=0 exactly 16 cycles after entering WAIT_LOW; next request completes normally.
- rst_n asserted during WAIT_HIGH -> all outputs 0 immediately; no rsp pulse; after release, a new req0 completes with the correct ciphertext.
- DES_ARB_CBC_EN, iv=0 with iv_load=1: block1 -> 85E813540F0AB405. Then encrypt the same plaintext again -> result matches the reference model DES(pt ^ 85E813540F0AB405). Decrypting both blocks with the same iv recovers the plaintexts.
